pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter width in bits.
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction/payload width in bits.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of each performance counter.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, upstream holds a valid pc/inst.
REQ-007 SHALL have port in_ready, output, 1, stage can accept this cycle.
REQ-008 SHALL have port in_pc, input, PC_W, upstream pc.
REQ-009 SHALL have port in_inst, input, INST_W, upstream instruction.
REQ-010 SHALL have port flush, input, 1, discard all held and incoming entries.
REQ-011 SHALL have port out_valid, output, 1, out_pc/out_inst are valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts this cycle.
REQ-013 SHALL have port out_pc, output, PC_W, held pc.
REQ-014 SHALL have port out_inst, output, INST_W, held instruction.
REQ-015 SHALL have port stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0 (PIPE_PERF_CNT_EN only).
REQ-016 SHALL have port flush_cnt, output, CNT_W, cycles with flush=1 (PIPE_PERF_CNT_EN only).

Function
REQ-017 SHALL be a two-entry skid buffer (main + skid register) with states EMPTY, ONE, FULL.
REQ-018 SHALL transfer in when in_valid&in_ready, and out when out_valid&out_ready, both at the clock edge.
REQ-019 SHALL drive in_ready=1 in EMPTY/ONE, 0 in FULL, from registered state only (no combinational path from out_ready).
REQ-020 SHALL drive out_valid=1 in ONE/FULL, and present the oldest entry from the main register.
REQ-021 SHALL have 1-cycle latency: an entry accepted in EMPTY appears on out_* the next cycle.
REQ-022 SHALL sustain one transfer per cycle when in_valid=out_ready=1 continuously.
REQ-023 SHALL transition EMPTY->ONE on in-only; ONE->FULL on in-only (skid loaded); ONE->EMPTY on out-only; ONE->ONE on in+out (main reloaded); FULL->ONE on out (skid moves to main).
REQ-024 SHALL preserve strict FIFO order; no entry is duplicated or dropped except by flush.
REQ-025 SHALL drive out_pc and out_inst to all-zero whenever out_valid=0.
REQ-026 SHALL, on flush=1, enter EMPTY next cycle, zero both registers, and ignore in_valid that cycle, regardless of out_ready.
REQ-027 SHALL give flush priority over reset-free handshakes; flush with out_ready=1 still counts no output transfer downstream beyond that cycle's presented entry.
REQ-028 SHALL hold out_* stable while out_valid=1 and out_ready=0.

Reset
REQ-029 SHALL, when rst=0 at a clock edge, set state EMPTY, out_valid=0, in_ready=1, out_pc=0, out_inst=0, skid=0, stall_cnt=0, flush_cnt=0.
REQ-030 SHALL apply reset mid-operation identically, discarding all held entries.

Configuration
REQ-031 SHALL, with PIPE_PERF_CNT_EN defined, implement stall_cnt and flush_cnt as saturating counters at 2^CNT_W-1.
REQ-032 SHALL, without PIPE_PERF_CNT_EN, omit both counter ports and all counter logic.

Structure
REQ-033 SHALL place the state enumeration (EMPTY, ONE, FULL) and default widths in shared package pipe_pkg.
REQ-034 SHALL implement counters in sub-module sat_counter (parameter CNT_W), instantiated twice.

Verification
REQ-035 SHALL cover: reset then in_valid=1, pc=0x100, inst=0x00500093, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_inst=0x00500093.
REQ-036 SHALL cover: out_ready=0, push pc 0x200 then 0x204 -> in_ready=0 after 2nd; release out_ready -> 0x200 then 0x204 in order, no loss.
REQ-037 SHALL cover: FULL with 0x300/0x304, flush=1 plus in_valid=1 pc 0x308 -> next cycle out_valid=0, out_pc=0, in_ready=1, 0x308 never appears.
REQ-038 SHALL cover: 8 back-to-back pushes 0x0..0x1C with out_ready=1 -> 8 consecutive output cycles, in_ready stays 1.
REQ-039 SHALL cover: rst=0 while FULL -> next cycle out_valid=0, in_ready=1, outputs zero.
REQ-040 SHALL cover (PIPE_PERF_CNT_EN, CNT_W=2): 5 stall cycles -> stall_cnt=3 saturated; 2 flushes -> flush_cnt=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline skid register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = pipe_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer (main + skid register) for a pc/inst pipeline stage.
// Define PIPE_PERF_CNT_EN to add the stall/flush saturating performance counters.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    pipe_state_t       state;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] main_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;

    // Main register is kept zero whenever empty, so it drives out_* directly.
    assign out_pc   = main_pc;
    assign out_inst = main_inst;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_pc   <= '0;
            main_inst <= '0;
            skid_pc   <= '0;
            skid_inst <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_pc   <= in_pc;
                        main_inst <= in_inst;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    case ({in_valid, out_ready})
                        2'b10: begin
                            skid_pc   <= in_pc;
                            skid_inst <= in_inst;
                            in_ready  <= 1'b0;
                            state     <= FULL;
                        end
                        2'b01: begin
                            main_pc   <= '0;
                            main_inst <= '0;
                            out_valid <= 1'b0;
                            state     <= EMPTY;
                        end
                        2'b11: begin
                            main_pc   <= in_pc;
                            main_inst <= in_inst;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (out_ready) begin
                        main_pc   <= skid_pc;
                        main_inst <= skid_inst;
                        skid_pc   <= '0;
                        skid_inst <= '0;
                        in_ready  <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    main_pc   <= '0;
                    main_inst <= '0;
                    skid_pc   <= '0;
                    skid_inst <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: queue-based reference model plus directed literal checks.
// Build with PIPE_PERF_CNT_EN defined to also exercise the counters at CNT_W=2.
module tb_pipe_skid_reg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    entry_t q[$];
    bit     m_ok = 1'b0;
    int     stall_m = 0;
    int     flush_m = 0;

    pipe_skid_reg #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is just a FIFO of depth two.
    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            stall_m = 0;
            flush_m = 0;
            m_ok    = 1'b1;
        end else begin
            if (q.size() > 0 && !out_ready && stall_m < CNT_MAX) stall_m++;
            if (flush && flush_m < CNT_MAX) flush_m++;
            if (flush) begin
                q.delete();
            end else begin
                bit pop_ok;
                bit push_ok;
                pop_ok  = (q.size() > 0) && out_ready;
                push_ok = in_valid && (q.size() < 2);
                if (pop_ok) void'(q.pop_front());
                if (push_ok) q.push_back('{pc: in_pc, inst: in_inst});
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("mdl_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("mdl_in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("mdl_out_pc", 64'(out_pc), (q.size() > 0) ? 64'(q[0].pc) : 64'd0);
            chk("mdl_out_inst", 64'(out_inst), (q.size() > 0) ? 64'(q[0].inst) : 64'd0);
`ifdef PIPE_PERF_CNT_EN
            chk("mdl_stall_cnt", 64'(stall_cnt), 64'(stall_m));
            chk("mdl_flush_cnt", 64'(flush_cnt), 64'(flush_m));
`endif
        end
    end

    task automatic cyc(input logic v, input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                       input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 0; in_pc = '0; in_inst = '0; out_ready = 0; flush = 0; rst = 0;

        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_pc", 64'(out_pc), 64'd0);

        // single entry, one-cycle latency
        cyc(1, 32'h100, 32'h0050_0093, 1, 0, 1);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_out_pc", 64'(out_pc), 64'h100);
        chk("lat_out_inst", 64'(out_inst), 64'h0050_0093);
        cyc(0, 0, 0, 1, 0, 1);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // backpressure fills the skid register
        cyc(1, 32'h200, 32'hA200, 0, 0, 1);
        chk("bp1_in_ready", 64'(in_ready), 64'd1);
        cyc(1, 32'h204, 32'hA204, 0, 0, 1);
        chk("bp2_in_ready", 64'(in_ready), 64'd0);
        chk("bp2_out_pc", 64'(out_pc), 64'h200);
        cyc(1, 32'h208, 32'hA208, 0, 0, 1);
        chk("hold_out_pc", 64'(out_pc), 64'h200);
        chk("hold_out_inst", 64'(out_inst), 64'hA200);
        cyc(0, 0, 0, 1, 0, 1);
        chk("rel1_out_pc", 64'(out_pc), 64'h204);
        chk("rel1_in_ready", 64'(in_ready), 64'd1);
        cyc(0, 0, 0, 1, 0, 1);
        chk("rel2_out_valid", 64'(out_valid), 64'd0);

        // flush while FULL beats a simultaneous push
        cyc(1, 32'h300, 32'hA300, 0, 0, 1);
        cyc(1, 32'h304, 32'hA304, 0, 0, 1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cyc(1, 32'h308, 32'hA308, 1, 1, 1);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_pc", 64'(out_pc), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 1);
            chk("fl_no_308", 64'(out_valid), 64'd0);
        end

        // streaming at one transfer per cycle
        for (int i = 0; i < 8; i++) begin
            cyc(1, PC_W'(i * 4), INST_W'(32'hB000 + i), 1, 0, 1);
            chk("strm_out_valid", 64'(out_valid), 64'd1);
            chk("strm_out_pc", 64'(out_pc), 64'(i * 4));
            chk("strm_in_ready", 64'(in_ready), 64'd1);
        end
        cyc(0, 0, 0, 1, 0, 1);
        chk("strm_end_valid", 64'(out_valid), 64'd0);

        // mixed pattern: pushes and pops with intermittent stalls
        for (int i = 0; i < 12; i++) begin
            cyc(i % 3 != 2, PC_W'(32'h400 + i * 4), INST_W'(32'hC000 + i), i % 4 != 1, 0, 1);
        end

        // reset while FULL
        cyc(1, 32'h500, 32'hA500, 0, 0, 1);
        cyc(1, 32'h504, 32'hA504, 0, 0, 1);
        cyc(1, 32'h508, 32'hA508, 0, 0, 0);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_out_pc", 64'(out_pc), 64'd0);
        chk("mrst_out_inst", 64'(out_inst), 64'd0);

`ifdef PIPE_PERF_CNT_EN
        chk("cnt_rst_stall", 64'(stall_cnt), 64'd0);
        cyc(1, 32'h600, 32'hA600, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
        chk("cnt_stall_sat", 64'(stall_cnt), 64'd3);
        chk("cnt_flush_zero", 64'(flush_cnt), 64'd0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        chk("cnt_flush_two", 64'(flush_cnt), 64'd2);
`endif

        cyc(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
